// File: rtl/bin2oct_decoder_pkg.sv
// Shared definitions for the binary-to-octal one-hot decoder.
// Holds the buffer FSM state type, the code/symbol widths and the
// reference one-hot conversion used by the decode sub-module.
package bin2oct_decoder_pkg;

    localparam int unsigned OCT_W = 8;
    localparam int unsigned BIN_W = 3;

    // Occupancy of the 2-entry in-order buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    function automatic logic [OCT_W-1:0] bin2onehot(input logic [BIN_W-1:0] bin);
        logic [OCT_W-1:0] oh;
        oh      = '0;
        oh[bin] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bin2oct_decoder_if.sv
// Handshake bundle for bin2oct_decoder.
//   in_valid/in_bin/in_ready    : upstream code stream (3-bit codes)
//   out_valid/out_oct/out_ready : downstream one-hot symbol stream
// master : the environment driving codes and accepting symbols
// slave  : the decoder itself
interface bin2oct_decoder_if;
    import bin2oct_decoder_pkg::*;

    logic             in_valid;
    logic [BIN_W-1:0] in_bin;
    logic             in_ready;
    logic             out_valid;
    logic [OCT_W-1:0] out_oct;
    logic             out_ready;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_oct
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_oct
    );

endinterface

// File: rtl/oct_onehot_dec.sv
// Combinational 3-to-8 one-hot decoder.
//   bin : binary octal digit, bit 2 is the MSB
//   oct : one-hot result, bit k set for code k
module oct_onehot_dec
    import bin2oct_decoder_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [OCT_W-1:0] oct
);

    assign oct = bin2onehot(bin);

endmodule

// File: rtl/bin2oct_decoder.sv
// Buffered binary-to-octal one-hot decoder.
// Accepts 3-bit codes over a valid/ready handshake, holds up to two in
// arrival order and presents the oldest one as a one-hot symbol downstream.
//   clk       : clock, rising edge active
//   rst_n     : asynchronous active-low reset
//   clr       : synchronous clear of buffer and counter (wins over push/pop)
//   bus       : code/symbol handshakes (slave side)
//   sym_count : saturating count of delivered symbols
module bin2oct_decoder
    import bin2oct_decoder_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    bin2oct_decoder_if.slave   bus,
    output logic [COUNT_W-1:0] sym_count
);

    state_e           state_q, state_d;
    logic [BIN_W-1:0] head_q, head_d;   // oldest buffered code
    logic [BIN_W-1:0] tail_q, tail_d;   // second code, valid only in FULL
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [OCT_W-1:0] dec_oct;
    logic             push;
    logic             pop;

    // Handshake flags are decodes of the state register only, so in_ready
    // never has a combinational path from out_ready.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clr) begin
            state_d = EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = bus.in_bin;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_d  = bus.in_bin;
                            state_d = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        // Old head leaves, new code becomes the head.
                        2'b11: head_d = bus.in_bin;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (pop && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    oct_onehot_dec u_dec (
        .bin (head_q),
        .oct (dec_oct)
    );

    // Gate with out_valid so a stale head never shows as a symbol.
    assign bus.out_oct = bus.out_valid ? dec_oct : '0;
    assign sym_count   = cnt_q;

endmodule

// File: tb/tb_bin2oct_decoder.sv
// Self-checking bench for bin2oct_decoder: two instances (COUNT_W=8 and
// COUNT_W=2) driven with identical stimulus and compared every cycle
// against a queue-based reference model, plus directed scenario checks.
module tb_bin2oct_decoder;
    import bin2oct_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bin2oct_decoder_if bus8();
    bin2oct_decoder_if bus2();
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    assign bus2.in_valid  = bus8.in_valid;
    assign bus2.in_bin    = bus8.in_bin;
    assign bus2.out_ready = bus8.out_ready;

    bin2oct_decoder #(.COUNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus8),
        .sym_count (cnt8)
    );

    bin2oct_decoder #(.COUNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus2),
        .sym_count (cnt2)
    );

    // Reference model: codes in arrival order, and pops since last clear.
    int          q[$];
    int unsigned m_pops;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          exp37[5] = '{1, 2, 3, 3, 3};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [31:0] e_oct;
        e_oct = (q.size() > 0) ? (32'd1 << q[0]) : 32'd0;
        check_eq({ph, ":vld8"}, {31'd0, bus8.out_valid}, {31'd0, q.size() > 0});
        check_eq({ph, ":rdy8"}, {31'd0, bus8.in_ready}, {31'd0, q.size() < 2});
        check_eq({ph, ":oct8"}, {24'd0, bus8.out_oct}, e_oct);
        check_eq({ph, ":oct2"}, {24'd0, bus2.out_oct}, e_oct);
        check_eq({ph, ":cnt8"}, {24'd0, cnt8}, (m_pops > 255) ? 32'd255 : m_pops);
        check_eq({ph, ":cnt2"}, {30'd0, cnt2}, (m_pops > 3) ? 32'd3 : m_pops);
    endtask

    task automatic set_in(input bit v, input logic [2:0] b, input bit ordy, input bit c);
        bus8.in_valid  = v;
        bus8.in_bin    = b;
        bus8.out_ready = ordy;
        clr            = c;
    endtask

    // One clock: check before the edge, then advance the model by the
    // handshake rules applied to the inputs currently driven.
    task automatic tick(input string ph);
        bit push, pop;
        @(negedge clk);
        check_outputs(ph);
        push = bus8.in_valid && (q.size() < 2);
        pop  = bus8.out_ready && (q.size() > 0);
        @(posedge clk);
        #1;
        if (clr) begin
            q.delete();
            m_pops = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_pops++;
            end
            if (push) q.push_back(int'(bus8.in_bin));
        end
    endtask

    initial begin
        q.delete();
        m_pops = 0;
        set_in(1'b0, 3'd0, 1'b0, 1'b0);

        // Reset values while rst_n is held low.
        #12;
        check_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Push 5 straight after reset; symbol next cycle, then counted.
        set_in(1'b1, 3'd5, 1'b1, 1'b0);
        tick("r33a");
        check_eq("r33_vld", {31'd0, bus8.out_valid}, 32'd1);
        check_eq("r33_oct", {24'd0, bus8.out_oct}, 32'h20);
        set_in(1'b0, 3'd0, 1'b1, 1'b0);
        tick("r33b");
        check_eq("r33_cnt", {24'd0, cnt8}, 32'd1);

        // Fill with 0, 7; third push of 2 is dropped.
        set_in(1'b1, 3'd0, 1'b0, 1'b0);
        tick("r34a");
        set_in(1'b1, 3'd7, 1'b0, 1'b0);
        tick("r34b");
        check_eq("r34_full_rdy", {31'd0, bus8.in_ready}, 32'd0);
        set_in(1'b1, 3'd2, 1'b0, 1'b0);
        tick("r34c");
        check_eq("r34_hold_oct", {24'd0, bus8.out_oct}, 32'h01);
        set_in(1'b0, 3'd0, 1'b1, 1'b0);
        tick("r35a");
        check_eq("r35_second", {24'd0, bus8.out_oct}, 32'h80);
        tick("r35b");
        check_eq("r35_empty", {31'd0, bus8.out_valid}, 32'd0);

        // Simultaneous push and pop in ONE.
        set_in(1'b1, 3'd1, 1'b0, 1'b0);
        tick("r36a");
        set_in(1'b1, 3'd6, 1'b1, 1'b0);
        check_eq("r36_now", {24'd0, bus8.out_oct}, 32'h02);
        tick("r36b");
        check_eq("r36_next", {24'd0, bus8.out_oct}, 32'h40);
        check_eq("r36_one", {30'd0, bus8.out_valid, bus8.in_ready}, 32'd3);
        set_in(1'b0, 3'd0, 1'b1, 1'b0);
        tick("r36c");

        // Saturation of the narrow counter.
        set_in(1'b0, 3'd0, 1'b0, 1'b1);
        tick("r37clr");
        set_in(1'b1, 3'd3, 1'b1, 1'b0);
        tick("r37a");
        for (int i = 0; i < 5; i++) begin
            tick("r37");
            check_eq("r37_cnt2", {30'd0, cnt2}, exp37[i]);
        end
        set_in(1'b0, 3'd0, 1'b1, 1'b0);
        tick("r37d");

        // clr while FULL with a push: everything gone.
        set_in(1'b1, 3'd4, 1'b0, 1'b0);
        tick("r38a");
        tick("r38b");
        set_in(1'b1, 3'd5, 1'b1, 1'b1);
        tick("r38c");
        check_eq("r38_vld", {31'd0, bus8.out_valid}, 32'd0);
        check_eq("r38_oct", {24'd0, bus8.out_oct}, 32'h00);
        check_eq("r38_cnt", {24'd0, cnt8}, 32'd0);
        set_in(1'b0, 3'd0, 1'b0, 1'b0);
        tick("r38d");

        // Asynchronous reset mid-cycle while FULL, then push right after.
        set_in(1'b1, 3'd6, 1'b0, 1'b0);
        tick("r39a");
        tick("r39b");
        set_in(1'b0, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_pops = 0;
        check_eq("r39_rdy", {31'd0, bus8.in_ready}, 32'd1);
        check_eq("r39_vld", {31'd0, bus8.out_valid}, 32'd0);
        check_eq("r39_oct", {24'd0, bus8.out_oct}, 32'h00);
        check_outputs("r39");
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_in(1'b1, 3'd3, 1'b1, 1'b0);
        tick("r29");
        check_eq("r29_oct", {24'd0, bus8.out_oct}, 32'h08);

        // Back-to-back sweep of all codes.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 3'(k), 1'b1, 1'b0);
            tick("r40");
            check_eq("r40_oct", {24'd0, bus8.out_oct}, 32'd1 << k);
        end
        set_in(1'b0, 3'd0, 1'b1, 1'b0);
        tick("r40end");

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/bin2oct_decoder.md
BIN2OCT_DECODER -- requirements
Module: bin2oct_decoder

Interface
REQ-001 Parameter COUNT_W, default 8, sets the width of the decoded-symbol counter (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clr  input  1  synchronous clear of buffer and counter, active-high.
REQ-005 in_valid  input  1  a 3-bit code is offered on in_bin.
REQ-006 in_bin  input  3  binary octal digit to decode; bit 2 is the MSB.
REQ-007 in_ready  output  1  the block can accept a code this cycle.
REQ-008 out_valid  output  1  out_oct holds a valid decoded symbol.
REQ-009 out_oct  output  8  one-hot decoded symbol: bit k set for code k.
REQ-010 out_ready  input  1  the downstream stage accepts out_oct this cycle.
REQ-011 sym_count  output  COUNT_W  saturating count of symbols delivered downstream.

Function
REQ-012 The block SHALL accept a code on any cycle where in_valid and in_ready are both 1 (push).
REQ-013 The block SHALL deliver a symbol on any cycle where out_valid and out_ready are both 1 (pop).
REQ-014 The block SHALL store accepted codes in a 2-entry in-order buffer controlled by the FSM states EMPTY, ONE and FULL.
REQ-015 FSM transitions SHALL be as follows:
- EMPTY: push -> ONE.
- ONE: push without pop -> FULL; pop without push -> EMPTY; push with pop -> ONE.
- FULL: pop -> ONE.
- No other transition occurs.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it is a registered function of state only and never depends on out_ready.
REQ-017 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-018 A code pushed in cycle N SHALL appear on out_oct with out_valid=1 in cycle N+1 when the buffer was EMPTY at the push (latency 1).
REQ-019 out_oct SHALL be the one-hot decode of the oldest buffered code, giving exactly one bit set whenever out_valid=1.
REQ-020 out_oct SHALL be 8'h00 whenever out_valid=0; X is never driven.
REQ-021 out_oct and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 sym_count SHALL increment by 1 on each pop and SHALL hold at 2^COUNT_W-1 once reached, with no wrap.
REQ-023 A push attempted in FULL (in_valid=1, in_ready=0) SHALL be ignored and SHALL leave state and data unchanged.
REQ-024 A push and a pop in the same cycle in ONE SHALL deliver the old entry and store the new one.
REQ-025 clr=1 SHALL force the EMPTY state and set sym_count to 0 on the next edge.
REQ-026 clr SHALL take priority over a push or pop in the same cycle; that push is discarded and that pop is not counted.

Reset
REQ-027 While rst_n=0 the block SHALL immediately force the following, independent of clk:
- state = EMPTY, in_ready = 1, out_valid = 0;
- out_oct = 8'h00, sym_count = 0;
- buffer contents = 0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered codes.
REQ-029 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state enum (EMPTY, ONE, FULL);
- the constant OCT_W=8 and the constant BIN_W=3;
- a pure function bin2onehot(3-bit) returning 8-bit.
REQ-031 The one-hot decode SHALL be a sub-module oct_onehot_dec (combinational, 3-in/8-out).
REQ-032 oct_onehot_dec SHALL be instantiated once on the buffer head output.

Verification
REQ-033 Reset then push in_bin=3'd5 with out_ready=1 -> next cycle out_valid=1, out_oct=8'b0010_0000, then sym_count=1.
REQ-034 out_ready=0, push 3'd0 then 3'd7 -> in_ready=0 in FULL, and a third push of 3'd2 is ignored.
REQ-035 Continuing REQ-034, raise out_ready -> pops deliver 8'h01 then 8'h80, and the dropped code 3'd2 never appears.
REQ-036 In state ONE holding 3'd1, push 3'd6 with out_ready=1 -> out_oct=8'h02 this cycle, 8'h40 next cycle, state stays ONE.
REQ-037 COUNT_W=2, pop 5 symbols -> sym_count reads 1,2,3,3,3.
REQ-038 Assert clr while FULL with a simultaneous push -> next cycle out_valid=0, out_oct=8'h00, sym_count=0, push lost.
REQ-039 Drop rst_n asynchronously mid-cycle while FULL -> outputs reach reset values before the next clk edge.
REQ-040 Sweep all 8 codes back-to-back -> out_oct is 1<<k for each code k, in order, with no bubbles.
